// File: rtl/fifo_txmod_if.sv
// FIFO-to-UART transmitter bus: FIFO status/read data in, FIFO enables and UART line out.
// The master side is the transmitter; the slave side is the FIFO/line observer.
interface fifo_txmod_if;
  logic [1:0] iTag;
  logic [7:0] iData;
  logic [1:0] oEn;
  logic       oTX;
  logic       oBusy;

  modport master (input iTag, input iData, output oEn, output oTX, output oBusy);
  modport slave  (output iTag, output iData, input oEn, input oTX, input oBusy);
endinterface

// File: rtl/fifo_txmod.sv
// Pops bytes from a registered-read FIFO and sends them as 8N1 UART frames, LSB first.
// Define FIFO_TXMOD_PARITY_EN to insert an even-parity bit between data and stop.
module fifo_txmod #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic          CLOCK,
  input logic          RESET,
  fifo_txmod_if.master bus
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef FIFO_TXMOD_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_idx;
  logic [15:0] bit_timer;
  logic        timer_done;
  logic        tx_line;
  logic        unused_full;
`ifdef FIFO_TXMOD_PARITY_EN
  logic        parity_bit;
`endif

  // The FIFO full flag is irrelevant to a pure consumer.
  assign unused_full = bus.iTag[1];
  assign timer_done  = (bit_timer == 16'd0);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_line    = 1'b1;
    case (state)
      IDLE:  if (!bus.iTag[0]) state_next = POP;
      POP:   state_next = LOAD;
      LOAD:  state_next = START;
      START: begin
        tx_line = 1'b0;
        if (timer_done) state_next = DATA;
      end
      DATA: begin
        tx_line = shift_reg[0];
        if (timer_done && bit_idx == 3'd7) begin
`ifdef FIFO_TXMOD_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef FIFO_TXMOD_PARITY_EN
      PARITY: begin
        tx_line = parity_bit;
        if (timer_done) state_next = STOP;
      end
`endif
      STOP:    if (timer_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read data arrives one cycle after the POP strobe, so capture happens in LOAD.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      shift_reg <= 8'd0;
      bit_idx   <= 3'd0;
      bit_timer <= 16'd0;
    end else begin
      case (state)
        LOAD: begin
          shift_reg <= bus.iData;
          bit_idx   <= 3'd0;
          bit_timer <= BIT_LAST;
        end
        DATA: begin
          if (timer_done) begin
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + 3'd1;
            bit_timer <= BIT_LAST;
          end else begin
            bit_timer <= bit_timer - 16'd1;
          end
        end
        START,
`ifdef FIFO_TXMOD_PARITY_EN
        PARITY,
`endif
        STOP: begin
          if (timer_done) bit_timer <= (state == STOP) ? 16'd0 : BIT_LAST;
          else            bit_timer <= bit_timer - 16'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef FIFO_TXMOD_PARITY_EN
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)             parity_bit <= 1'b0;
    else if (state == LOAD) parity_bit <= ^bus.iData;
  end
`endif

  assign bus.oTX   = tx_line;
  assign bus.oEn   = {1'b0, state == POP};
  assign bus.oBusy = (state != IDLE);

endmodule

// File: tb/tb_fifo_txmod.sv
// Bench for fifo_txmod: FIFO model drives the bus, a UART receiver decodes oTX against a scoreboard.
// Build with FIFO_TXMOD_PARITY_EN defined to exercise the parity frame.
module tb_fifo_txmod;

   localparam int CPB = 4;
`ifdef FIFO_TXMOD_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;
   fifo_txmod_if bus();

   fifo_txmod #(.CLKS_PER_BIT(CPB)) dut (
      .CLOCK(CLOCK),
      .RESET(RESET),
      .bus  (bus.master)
   );

   always #5 CLOCK = ~CLOCK;

   int cyc = 0;
   always @(posedge CLOCK) cyc <= cyc + 1;

   logic [7:0] fifo_q[$];
   logic [7:0] push_req[$];
   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int pushes = 0;
   int pops = 0;
   int frames_done = 0;
   int wr_seen = 0;
   int last_pop_cyc = -100;
   int exp_pop_cyc = -1;
   bit hold = 1'b0;
   bit full_noise = 1'b0;
   logic rx_s [FRAME_CYC];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, req, req, cyc);
      end
   endtask

   // Stimulus is a FIFO push; the same byte is what the line must eventually carry.
   task automatic applyStimulus(input logic [7:0] b);
      int k = 0;
      while ((push_req.size() + fifo_q.size()) >= 16 && k < 5000) begin
         @(negedge CLOCK);
         k++;
      end
      if (k >= 5000) checkOutput("push_space_timeout", 1, 0);
      push_req.push_back(b);
      exp_q.push_back(b);
      pushes++;
   endtask

   task automatic waitIdle(input int limit);
      int k = 0;
      while ((push_req.size() != 0 || fifo_q.size() != 0 || exp_q.size() != 0 ||
              bus.oBusy !== 1'b0) && k < limit) begin
         @(negedge CLOCK);
         k++;
      end
      if (k >= limit) checkOutput("drain_timeout", 1, 0);
      repeat (5) @(negedge CLOCK);
   endtask

   // 16-deep FIFO with one-cycle registered read; iData is garbage on non-read cycles.
   initial begin
      bit rd;
      bit prev_rd;
      bit noise;
      bus.iTag  = 2'b01;
      bus.iData = 8'h00;
      prev_rd   = 1'b0;
      forever begin
         @(negedge CLOCK);
         rd = RESET && (bus.oEn[0] === 1'b1);
         if (bus.oEn[1] !== 1'b0) wr_seen++;
         if (rd) begin
            checkOutput("pop_single_cycle", {31'd0, prev_rd}, 0);
            if (exp_pop_cyc >= 0) begin
               checkOutput("pop_latency", cyc, exp_pop_cyc);
               exp_pop_cyc = -1;
            end
            last_pop_cyc = cyc;
         end
         prev_rd = rd;
         @(posedge CLOCK);
         #1;
         if (rd) begin
            if (fifo_q.size() == 0) begin
               checkOutput("pop_when_empty", 1, 0);
               bus.iData = 8'($urandom);
            end else begin
               bus.iData = fifo_q.pop_front();
               pops++;
            end
         end else begin
            bus.iData = 8'($urandom);
         end
         if (push_req.size() > 0 && fifo_q.size() < 16) begin
            if (fifo_q.size() == 0 && !hold && RESET && bus.oBusy === 1'b0)
               exp_pop_cyc = cyc + 1;
            fifo_q.push_back(push_req.pop_front());
         end
         noise = full_noise ? 1'($urandom_range(1, 0)) : 1'b0;
         bus.iTag = {(fifo_q.size() >= 16) ^ noise, hold || (fifo_q.size() == 0)};
      end
   end

   // UART receiver and busy-length monitor, both sampled on the falling edge.
   initial begin
      bit active;
      bit b2b;
      int rx_n;
      int gap;
      int busy_run;
      int bad;
      logic [7:0] data;
      logic [7:0] expb;
      active = 0; b2b = 0; rx_n = 0; gap = 0; busy_run = 0;
      forever begin
         @(negedge CLOCK);
         if (!RESET) begin
            active = 0; b2b = 0; rx_n = 0; gap = 0; busy_run = 0;
         end else begin
            if (bus.oBusy === 1'b1) busy_run++;
            else if (busy_run > 0) begin
               checkOutput("busy_length", busy_run, FRAME_CYC + 2);
               busy_run = 0;
            end
            if (!active) begin
               if (bus.oTX === 1'b0) begin
                  active   = 1;
                  rx_s[0]  = 1'b0;
                  rx_n     = 1;
                  if (b2b) checkOutput("interframe_gap", gap, 3);
                  checkOutput("pop_to_line", cyc, last_pop_cyc + 2);
                  b2b = 0;
               end else if (bus.oTX !== 1'b1) begin
                  checkOutput("idle_line_known", {31'd0, bus.oTX}, 1);
               end else begin
                  gap++;
               end
            end else begin
               rx_s[rx_n] = bus.oTX;
               rx_n++;
               if (rx_n == FRAME_CYC) begin
                  bad = 0;
                  for (int k = 0; k < FRAME_BITS; k++)
                     for (int j = 1; j < CPB; j++)
                        if (rx_s[k*CPB+j] !== rx_s[k*CPB]) bad++;
                  checkOutput("bit_shape", bad, 0);
                  for (int k = 0; k < 8; k++) data[k] = rx_s[(k+1)*CPB];
                  checkOutput("stop_bit", {31'd0, rx_s[(FRAME_BITS-1)*CPB]}, 1);
                  if (exp_q.size() == 0) begin
                     checkOutput("unexpected_frame", {24'd0, data}, 32'hFFFF_FFFF);
                  end else begin
                     expb = exp_q.pop_front();
                     checkOutput("data_byte", {24'd0, data}, {24'd0, expb});
`ifdef FIFO_TXMOD_PARITY_EN
                     checkOutput("parity_bit", {31'd0, rx_s[9*CPB]}, {31'd0, ^expb});
`endif
                  end
                  frames_done++;
                  active = 0;
                  gap    = 0;
                  b2b    = (fifo_q.size() > 0) && !hold;
               end
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k;
      logic [7:0] burst [3];
      burst[0] = 8'h00; burst[1] = 8'hFF; burst[2] = 8'h3C;

      // Reset held with the FIFO empty, then released.
      repeat (3) @(negedge CLOCK);
      checkOutput("reset_tx", {31'd0, bus.oTX}, 1);
      checkOutput("reset_en", {30'd0, bus.oEn}, 0);
      checkOutput("reset_busy", {31'd0, bus.oBusy}, 0);
      #2 RESET = 1'b1;
      repeat (10) @(negedge CLOCK);
      checkOutput("idle_empty_busy", {31'd0, bus.oBusy}, 0);
      checkOutput("idle_empty_tx", {31'd0, bus.oTX}, 1);
      checkOutput("idle_empty_pops", pops, 0);

      $display("[TB] single byte 0xA5");
      applyStimulus(8'hA5);
      waitIdle(500);

      $display("[TB] burst of three");
      foreach (burst[i]) applyStimulus(burst[i]);
      waitIdle(1000);

      $display("[TB] full FIFO of sixteen");
      hold = 1'b1;
      for (int i = 0; i < 16; i++) applyStimulus(8'($urandom));
      k = 0;
      while (push_req.size() != 0 && k < 100) begin
         @(negedge CLOCK);
         k++;
      end
      repeat (4) @(negedge CLOCK);
      checkOutput("hold_no_pop_busy", {31'd0, bus.oBusy}, 0);
      hold = 1'b0;
      waitIdle(3000);

      $display("[TB] parity bytes 0x07 0x03");
      applyStimulus(8'h07);
      applyStimulus(8'h03);
      waitIdle(1000);

      $display("[TB] reset during bit 3 of 0x81");
      applyStimulus(8'h81);
      applyStimulus(8'h42);
      k = 0;
      while (bus.oTX !== 1'b0 && k < 200) begin
         @(negedge CLOCK);
         k++;
      end
      if (k >= 200) checkOutput("start_bit_timeout", 1, 0);
      repeat (4*CPB + 1) @(posedge CLOCK);
      #2;
      checkOutput("tx_before_reset", {31'd0, bus.oTX}, 0);
      RESET = 1'b0;
      #1;
      checkOutput("async_reset_tx", {31'd0, bus.oTX}, 1);
      checkOutput("async_reset_busy", {31'd0, bus.oBusy}, 0);
      checkOutput("async_reset_en", {30'd0, bus.oEn}, 0);
      while (pops > frames_done) begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         frames_done++;
      end
      exp_pop_cyc = -1;
      repeat (3) @(negedge CLOCK);
      #2 RESET = 1'b1;
      waitIdle(1000);

      $display("[TB] randomized traffic");
      full_noise = 1'b1;
      for (int i = 0; i < 40; i++) begin
         applyStimulus(8'($urandom));
         if ($urandom_range(3, 0) == 0) repeat ($urandom_range(60, 0)) @(negedge CLOCK);
      end
      waitIdle(5000);
      full_noise = 1'b0;

      checkOutput("write_enable_seen", wr_seen, 0);
      checkOutput("pop_count", pops, pushes);
      checkOutput("fifo_final_empty", fifo_q.size(), 0);
      checkOutput("final_busy", {31'd0, bus.oBusy}, 0);
      checkOutput("final_tx", {31'd0, bus.oTX}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
